// File: rtl/pipe_arb_pkg.sv
// Shared types for the pipe_arb_ctrl scheduler: FSM encoding, widths, tag layout.
// The tag's err bit exists only when FUNC_ONEHOT_CHK_EN is defined.
package pipe_arb_pkg;

  localparam int unsigned ID_W   = 1;
  localparam int unsigned FUNC_W = 8;
  localparam int unsigned OPND_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
`ifdef FUNC_ONEHOT_CHK_EN
    logic            err;
`endif
  } tag_t;

  function automatic logic is_onehot(input logic [FUNC_W-1:0] f);
    return (f != '0) && ((f & (f - FUNC_W'(1))) == '0);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick. On a tie the requester that did not win last gets the grant;
// last-winner resets to 1 so requester 0 wins the first tie.
module rr_arb2 (
  input  logic       clk,
  input  logic       res_n,
  input  logic [1:0] req,
  input  logic       upd,
  input  logic       upd_id,
  output logic       pick
);

  logic last_q;

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      last_q <= 1'b1;
    end else if (upd) begin
      last_q <= upd_id;
    end
  end

  always_comb begin
    case (req)
      2'b01:   pick = 1'b0;
      2'b10:   pick = 1'b1;
      default: pick = ~last_q;
    endcase
  end

endmodule

// File: rtl/pipe_arb_ctrl.sv
// Two-requester burst-bounded round-robin scheduler for the 2-stage ALU/parity datapath.
// Optional FUNC_ONEHOT_CHK_EN: non-one-hot func issues as a bubble func and returns rsp_err=1.
module pipe_arb_ctrl
  import pipe_arb_pkg::*;
#(
  parameter int unsigned BURST = 4,
  parameter int unsigned LAT   = 2
) (
  input  logic              clk,
  input  logic              res_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [OPND_W-1:0] req0_a,
  input  logic [OPND_W-1:0] req0_b,
  input  logic [FUNC_W-1:0] req0_func,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [OPND_W-1:0] req1_a,
  input  logic [OPND_W-1:0] req1_b,
  input  logic [FUNC_W-1:0] req1_func,
  output logic [OPND_W-1:0] dp_a,
  output logic [OPND_W-1:0] dp_b,
  output logic [FUNC_W-1:0] dp_func,
  input  logic              dp_gp,
  output logic              rsp_valid,
  output logic              rsp_id,
  output logic              rsp_gp,
  output logic              rsp_err
);

  localparam int unsigned CNT_W = $clog2(BURST + 1);

  arb_state_e        state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              acc, acc_id, pick, at_burst, own_v, oth_v;
  arb_state_e        oth_st;
  logic [FUNC_W-1:0] sel_func;
  tag_t              tag_in;
  tag_t              tag_q [LAT];

  assign req0_ready = (state_q == OWN0) && req0_valid;
  assign req1_ready = (state_q == OWN1) && req1_valid;
  assign acc        = req0_ready | req1_ready;
  assign acc_id     = req1_ready;

  rr_arb2 u_rr_arb2 (
    .clk    (clk),
    .res_n  (res_n),
    .req    ({req1_valid, req0_valid}),
    .upd    (acc),
    .upd_id (acc_id),
    .pick   (pick)
  );

  always_comb begin
    dp_a     = '0;
    dp_b     = '0;
    sel_func = '0;
    if (req0_ready) begin
      dp_a     = req0_a;
      dp_b     = req0_b;
      sel_func = req0_func;
    end else if (req1_ready) begin
      dp_a     = req1_a;
      dp_b     = req1_b;
      sel_func = req1_func;
    end
  end

  always_comb begin
    tag_in       = '0;
    tag_in.valid = acc;
    tag_in.id    = acc_id;
`ifdef FUNC_ONEHOT_CHK_EN
    tag_in.err   = acc && !is_onehot(sel_func);
    dp_func      = tag_in.err ? '0 : sel_func;
`else
    dp_func      = sel_func;
`endif
  end

  assign at_burst = (cnt_q == CNT_W'(BURST));
  assign own_v    = (state_q == OWN1) ? req1_valid : req0_valid;
  assign oth_v    = (state_q == OWN1) ? req0_valid : req1_valid;
  assign oth_st   = (state_q == OWN1) ? OWN0 : OWN1;

  // Burst count saturates at BURST; a full count only forces a switch when the other side waits.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req0_valid || req1_valid) begin
            state_q <= pick ? OWN1 : OWN0;
            cnt_q   <= CNT_W'(1);
          end
        end
        OWN0, OWN1: begin
          if (own_v) begin
            if (oth_v && at_burst) begin
              state_q <= oth_st;
              cnt_q   <= CNT_W'(1);
            end else if (!at_burst) begin
              cnt_q   <= cnt_q + CNT_W'(1);
            end
          end else if (oth_v) begin
            state_q <= oth_st;
            cnt_q   <= CNT_W'(1);
          end else begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      for (int i = 0; i < LAT; i++) tag_q[i] <= '0;
    end else begin
      tag_q[0] <= tag_in;
      for (int i = 1; i < LAT; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  // The tail lines up with dp_gp for the same beat.
  assign rsp_valid = tag_q[LAT-1].valid;
  assign rsp_id    = tag_q[LAT-1].id;
`ifdef FUNC_ONEHOT_CHK_EN
  assign rsp_err   = tag_q[LAT-1].err;
  assign rsp_gp    = tag_q[LAT-1].valid && !tag_q[LAT-1].err && dp_gp;
`else
  assign rsp_err   = 1'b0;
  assign rsp_gp    = tag_q[LAT-1].valid && dp_gp;
`endif

endmodule
